// File: rtl/uart_rx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_engine
// Brief    : UART receiver with line synchronizer, parity/framing/overrun flags.
// Revision : 1.0
// ============================================================================
module uart_rx_engine #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxLineIn,
    input  logic [3:0] Baud_Val,
    input  logic       Bit78,
    input  logic       ParityEn,
    input  logic       ParityOE,
    input  logic       read_ack,
    output logic [7:0] RxData,
    output logic       RxRdy,
    output logic       P_Error,
    output logic       F_Error,
    output logic       Over_Error,
    output logic       RxBusy
);

    localparam int CNT_W = 18;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] bit_period(input logic [3:0] sel);
        case (sel)
            4'd0:    return 18'd166667;
            4'd1:    return 18'd41667;
            4'd2:    return 18'd20833;
            4'd3:    return 18'd10417;
            4'd4:    return 18'd5208;
            4'd5:    return 18'd2604;
            4'd6:    return 18'd1302;
            4'd7:    return 18'd868;
            4'd8:    return 18'd434;
            4'd9:    return 18'd217;
            4'd10:   return 18'd109;
            default: return 18'd54;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             baud_q, baud_d;
    logic                   bit78_q, bit78_d;
    logic                   par_en_q, par_en_d;
    logic                   par_oe_q, par_oe_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             nbits_q, nbits_d;
    logic                   par_bit_q, par_bit_d;
    logic [7:0]             data_q, data_d;
    logic                   rdy_q, rdy_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   oerr_q, oerr_d;

    logic                   line_w;
    logic [CNT_W-1:0]       period_w;
    logic [CNT_W-1:0]       half_in_w;
    logic [7:0]             data_w;
    logic                   par_exp_w;

    assign line_w    = sync_q[SYNC_STAGES-1];
    assign period_w  = bit_period(baud_q);
    // Half period comes from the live input: it is loaded on the same edge the config is latched
    assign half_in_w = bit_period(Baud_Val) >> 1;
    // 7-bit frames shift only seven times, leaving the character in shift_q[7:1]
    assign data_w    = bit78_q ? shift_q : {1'b0, shift_q[7:1]};
    assign par_exp_w = (^data_w) ^ par_oe_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sync_q    <= '1;
            cnt_q     <= '0;
            baud_q    <= '0;
            bit78_q   <= 1'b0;
            par_en_q  <= 1'b0;
            par_oe_q  <= 1'b0;
            shift_q   <= '0;
            nbits_q   <= '0;
            par_bit_q <= 1'b0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            oerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            baud_q    <= baud_d;
            bit78_q   <= bit78_d;
            par_en_q  <= par_en_d;
            par_oe_q  <= par_oe_d;
            shift_q   <= shift_d;
            nbits_q   <= nbits_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            oerr_q    <= oerr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], RxLineIn};
        cnt_d     = cnt_q;
        baud_d    = baud_q;
        bit78_d   = bit78_q;
        par_en_d  = par_en_q;
        par_oe_d  = par_oe_q;
        shift_d   = shift_q;
        nbits_d   = nbits_q;
        par_bit_d = par_bit_q;
        data_d    = data_q;
        rdy_d     = rdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        oerr_d    = oerr_q;

        if (read_ack) begin
            rdy_d  = 1'b0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
            oerr_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!line_w) begin
                    cnt_d    = half_in_w - 18'd1;
                    baud_d   = Baud_Val;
                    bit78_d  = Bit78;
                    par_en_d = ParityEn;
                    par_oe_d = ParityOE;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 18'd1;
                end else if (!line_w) begin
                    cnt_d   = period_w - 18'd1;
                    nbits_d = '0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 18'd1;
                end else begin
                    shift_d = {line_w, shift_q[7:1]};
                    nbits_d = nbits_q + 3'd1;
                    cnt_d   = period_w - 18'd1;
                    if (nbits_q == (bit78_q ? 3'd7 : 3'd6)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 18'd1;
                end else begin
                    par_bit_d = line_w;
                    cnt_d     = period_w - 18'd1;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 18'd1;
                end else begin
                    // Commit overrides a coincident read_ack; overrun only if the old char was unread
                    data_d  = data_w;
                    rdy_d   = 1'b1;
                    perr_d  = par_en_q & (par_bit_q ^ par_exp_w);
                    ferr_d  = ~line_w;
                    oerr_d  = rdy_q & ~read_ack;
                    state_d = line_w ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (line_w) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign RxData     = data_q;
    assign RxRdy      = rdy_q;
    assign P_Error    = perr_q;
    assign F_Error    = ferr_q;
    assign Over_Error = oerr_q;
    assign RxBusy     = (state_q != S_IDLE);

endmodule
`default_nettype wire
